// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: N:1 stream multiplexer with round-robin arbitration, optional
// packet locking and a registered output stage.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data  [N*W-1:0]  channel i occupies bits [i*W +: W]
//   in_valid [N-1:0]    per-channel beat valid
//   in_last  [N-1:0]    per-channel end-of-packet flag
//   in_ready [N-1:0]    per-channel accept (one-hot or zero)
//   out_data [W-1:0]    registered data
//   out_last            registered end-of-packet flag
//   out_sel  [SW-1:0]   registered index of the source channel
//   out_valid           registered output valid
//   out_ready           sink accept
module mux_nx1_rr #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int LOCK = 1,
  localparam int SW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [SW-1:0]  out_sel,
  output logic           out_valid,
  input  logic           out_ready
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] lock_ch_q, lock_ch_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic          out_valid_q, out_valid_d;

  logic [SW-1:0] grant;
  logic          found;
  logic          space;
  logic          xfer;
  logic [W-1:0]  ch_data [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*W +: W];
  end

  // Grant selection. The search index is one bit wider than SW so that
  // ptr+k can exceed N-1 and be folded back for non-power-of-two N.
  always_comb begin
    logic [SW:0]   sum;
    logic [SW-1:0] cand;
    grant = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    if (state_q == LOCKED) begin
      grant = lock_ch_q;
      found = in_valid[lock_ch_q];
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        sum = {1'b0, ptr_q} + (SW+1)'(k);
        if (sum >= (SW+1)'(N)) begin
          sum = sum - (SW+1)'(N);
        end
        cand = sum[SW-1:0];
        if (!found && in_valid[cand]) begin
          found = 1'b1;
          grant = cand;
        end
      end
    end
  end

  // rst_n gates the handshake so nothing is accepted while reset is held.
  assign space = !out_valid_q || out_ready;
  assign xfer  = rst_n && space && found;

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_ch_d   = lock_ch_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = ch_data[grant];
      out_last_d  = in_last[grant];
      out_sel_d   = grant;
      out_valid_d = 1'b1;
      if ((LOCK != 0) && !in_last[grant]) begin
        state_d   = LOCKED;
        lock_ch_d = grant;
      end else begin
        state_d = IDLE;
        ptr_d   = (grant == SW'(N-1)) ? '0 : grant + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      lock_ch_q   <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_ch_q   <= lock_ch_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N:1 stream multiplexer with round-robin arbitration, packet locking and a registered output stage. It is the next generation of the team's 2:1 combinational mux, replacing the select input with valid/ready handshaking so several producers can share one downstream consumer. It sits between N packet sources and a single sink.

## Interface
Parameters:
- N, 4, number of input channels, 2..16, need not be a power of two
- W, 8, data width in bits, 1..256
- LOCK, 1, 1 = grant held until the beat with in_last; 0 = re-arbitrate every beat
- SW (localparam), max(1, clog2(N)), select width

Ports:
- clk  in  1  single clock, all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  N*W  channel i occupies bits [i*W +: W]
- in_valid  in  N  per-channel beat valid
- in_last  in  N  per-channel end-of-packet flag
- in_ready  out  N  per-channel accept, at most one bit high (one-hot or zero)
- out_data  out  W  registered data
- out_last  out  1  registered end-of-packet flag
- out_sel  out  SW  registered index of the channel that sourced the current out beat
- out_valid  out  1  registered output valid
- out_ready  in  1  sink accept

## Operation
- Transfer on input i when in_valid[i] & in_ready[i]; on output when out_valid & out_ready.
- Output register may load when `space = !out_valid | out_ready`.
- States: IDLE (no channel owns the output) and LOCKED (lock_ch owns it). LOCKED is only reachable with LOCK=1.
- IDLE grant: the first channel with in_valid high, searching ptr, ptr+1, …, N-1, 0, …, ptr-1. Selection is combinational in the same cycle.
- LOCKED grant: always lock_ch. Other channels are never granted, even if lock_ch is idle; lock_ch idle produces bubbles.
- in_ready[g] = space & in_valid[g] for the granted channel g. All other bits are 0. When no channel is valid, in_ready = 0.
- On a transfer from channel g:
  - the output register loads in_data[g], in_last[g] and g;
  - out_valid is set to 1.
- On an output transfer with no input transfer in the same cycle, out_valid is cleared. out_data, out_last and out_sel hold their values.
- State updates after a transfer from g:
  - LOCK=1, in_last[g]=0: go to LOCKED with lock_ch=g.
  - LOCK=1, in_last[g]=1: go to IDLE with ptr=(g+1) mod N.
  - LOCK=0: stay in IDLE with ptr=(g+1) mod N after every beat.
- Wrap-around: ptr=N-1 advances to 0. out_sel never takes a value ≥ N.
- Simultaneous events:
  - An output transfer and an input load in the same cycle replace the beat. Full rate is 1 beat/cycle.
  - When several channels are valid in IDLE, only the round-robin winner is granted.
- A producer dropping in_valid mid-packet is legal: the lock is kept.

## Timing
- Reset values while rst_n is low, applied asynchronously:
  - out_valid=0, out_data=0, out_last=0, out_sel=0;
  - state=IDLE, ptr=0, lock_ch=0;
  - in_ready forced to 0.
- Reset asserted mid-packet discards the lock and any held output beat. After release, arbitration restarts from ptr=0.
- Latency: a beat accepted at edge k is presented on out_* after edge k and held until out_ready is sampled high.
- Throughput: 1 beat/cycle sustained when out_ready=1, including across packet boundaries. There is no idle cycle between packets from different channels.
- With out_valid=1 and out_ready=0: all in_ready are 0 and out_* are stable (no change until accepted).
- in_ready depends combinationally on in_valid and out_ready. out_* are purely registered.

## Test plan
- Reset and first beat: hold rst_n=0 with in_valid=4'b1111, expect in_ready=0 and out_valid=0. Release with out_ready=1, expect channel 0 granted and out_sel=0, out_valid=1 one cycle later.
- Fairness, N=4, LOCK=0: all channels valid, single-beat packets, out_ready=1. Expect out_sel sequence 0,1,2,3,0,1 on consecutive cycles with no gaps.
- Packet lock, LOCK=1: channel 2 sends a 3-beat packet (last on beat 3) while channel 0 is continuously valid, and channel 2 drops valid for 2 cycles mid-packet. Expect in_ready[0]=0 throughout, then channel 3 checked first and channel 0 granted only after last.
- Backpressure: out_ready=0 for 5 cycles with out_data=8'hA5 held. Expect out_data=8'hA5 stable and in_ready=0; after out_ready=1, one beat per cycle resumes with none lost or duplicated.
- Wrap and odd N, N=3: only channel 2 valid, then channels 0 and 2 valid. Expect ptr to wrap to 0, the order 2,0,2,0 and out_sel never 3.
- Reset mid-packet: assert rst_n=0 while LOCKED on channel 1. Expect immediate out_valid=0; after release, channel 0 wins if valid.
